// File: rtl/spectro_frame_receiver_pkg.sv
// Shared constants and state encoding for the spectrogram readout link.
`default_nettype none

package spectro_frame_receiver_pkg;
  localparam int WORD_W    = 12;
  localparam int N_WORDS   = 16;
  localparam int RTC_INDEX = 0;
  localparam int IDX_W     = 4;
  localparam int CNT_W     = 4;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_SHIFT    = 3'd1;
  localparam logic [2:0] ST_NEXT     = 3'd2;
  localparam logic [2:0] ST_WAIT_EOF = 3'd3;
  localparam logic [2:0] ST_RESYNC   = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE     = ST_IDLE,
    S_SHIFT    = ST_SHIFT,
    S_NEXT     = ST_NEXT,
    S_WAIT_EOF = ST_WAIT_EOF,
    S_RESYNC   = ST_RESYNC
  } state_t;
endpackage

`default_nettype wire

// File: rtl/spectro_word_shifter.sv
// Word shift register and bit counter; o_done flags the sample that completes a word.
`default_nettype none

module spectro_word_shifter #(
  parameter int WORD_W    = 12,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_start,
  input  logic              i_shift,
  input  logic              i_sdata,
  output logic [WORD_W-1:0] o_word_next,
  output logic              o_done
);
  logic [WORD_W-1:0] r_shreg;
  logic [3:0]        r_bit_cnt;
  logic [WORD_W-1:0] w_base;

  // A start bit begins from an empty register so stale bits never leak in.
  assign w_base = i_start ? '0 : r_shreg;

  generate
    if (MSB_FIRST) begin : g_msb_first
      assign o_word_next = {w_base[WORD_W-2:0], i_sdata};
    end else begin : g_lsb_first
      assign o_word_next = {i_sdata, w_base[WORD_W-1:1]};
    end
  endgenerate

  assign o_done = i_shift && (r_bit_cnt == 4'(WORD_W - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_shreg   <= '0;
      r_bit_cnt <= '0;
    end else if (i_start) begin
      r_shreg   <= o_word_next;
      r_bit_cnt <= 4'd1;
    end else if (i_shift) begin
      r_shreg   <= o_word_next;
      r_bit_cnt <= o_done ? 4'd0 : r_bit_cnt + 4'd1;
    end else begin
      r_shreg   <= '0;
      r_bit_cnt <= '0;
    end
  end
endmodule

`default_nettype wire

// File: rtl/spectro_frame_receiver.sv
// Deserialises 16-word spectrogram frames into indexed words behind a valid/ready port.
`default_nettype none

module spectro_frame_receiver #(
  parameter int WORD_W    = spectro_frame_receiver_pkg::WORD_W,
  parameter int N_WORDS   = spectro_frame_receiver_pkg::N_WORDS,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sl_in,
  input  logic              sdata_in,
  input  logic              eof_in,
  output logic [WORD_W-1:0] word_data,
  output logic [3:0]        word_index,
  output logic              word_valid,
  input  logic              word_ready,
  output logic              frame_start,
  output logic              frame_done,
  output logic              frame_err,
  output logic              overrun_err
);
  import spectro_frame_receiver_pkg::*;

  state_t            r_state;
  logic [3:0]        r_word_idx;
  logic              w_start;
  logic              w_shift;
  logic              w_done;
  logic [WORD_W-1:0] w_word_next;

  // Any strobe inside a word is a framing fault, so such a cycle never shifts.
  assign w_start = ((r_state == S_IDLE) || (r_state == S_NEXT)) && sl_in;
  assign w_shift = (r_state == S_SHIFT) && !sl_in && !eof_in;

  spectro_word_shifter #(
    .WORD_W    (WORD_W),
    .MSB_FIRST (MSB_FIRST)
  ) u_shifter (
    .clk         (clk),
    .reset       (reset),
    .i_start     (w_start),
    .i_shift     (w_shift),
    .i_sdata     (sdata_in),
    .o_word_next (w_word_next),
    .o_done      (w_done)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_word_idx  <= '0;
      word_data   <= '0;
      word_index  <= '0;
      word_valid  <= 1'b0;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (sl_in) begin
            r_word_idx  <= 4'(RTC_INDEX);
            frame_start <= 1'b1;
            r_state     <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (sl_in || eof_in) begin
            frame_err <= 1'b1;
            r_state   <= S_RESYNC;
          end else if (w_done) begin
            r_state <= (r_word_idx < 4'(N_WORDS - 1)) ? S_NEXT : S_WAIT_EOF;
          end
        end
        S_NEXT: begin
          if (sl_in) begin
            r_word_idx <= r_word_idx + 4'd1;
            r_state    <= S_SHIFT;
          end else begin
            frame_err <= 1'b1;
            r_state   <= S_RESYNC;
          end
        end
        S_WAIT_EOF: begin
          if (eof_in) begin
            frame_done <= 1'b1;
            r_state    <= S_IDLE;
          end else begin
            frame_err <= 1'b1;
            r_state   <= S_RESYNC;
          end
        end
        S_RESYNC: begin
          if (eof_in) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase

      // Single-entry holding register: the newest word always wins.
      if (w_done) begin
        word_data   <= w_word_next;
        word_index  <= r_word_idx;
        word_valid  <= 1'b1;
        overrun_err <= word_valid && !word_ready;
      end else if (word_ready) begin
        word_valid <= 1'b0;
      end
    end
  end
endmodule

`default_nettype wire

// File: tb/tb_spectro_frame_receiver.sv
// Randomised bench for spectro_frame_receiver with an in-bench link model.
`default_nettype none

module tb_spectro_frame_receiver;
  localparam int W = 12;
  localparam int N = 16;

  logic        clk = 1'b0;
  logic        reset, sl_in, sdata_in, eof_in, word_ready;
  logic [W-1:0] word_data;
  logic [3:0]  word_index;
  logic        word_valid, frame_start, frame_done, frame_err, overrun_err;

  spectro_frame_receiver #(.WORD_W(W), .N_WORDS(N), .MSB_FIRST(1'b1)) dut (
    .clk(clk), .reset(reset), .sl_in(sl_in), .sdata_in(sdata_in), .eof_in(eof_in),
    .word_data(word_data), .word_index(word_index), .word_valid(word_valid),
    .word_ready(word_ready), .frame_start(frame_start), .frame_done(frame_done),
    .frame_err(frame_err), .overrun_err(overrun_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic rst; logic sl; logic sd; logic eof; logic [1:0] rmode;
  } ent_t;
  ent_t stream[$];
  int   cur_rmode = 1;
  int   hold0 = 0;

  int checks = 0;
  int errors = 0;

  // Link model: 0 idle, 1 inside a word, 2 expecting next SL, 3 expecting EOF, 4 hunting for EOF.
  int m_mode = 0;
  bit m_bits[$];
  int m_idx = 0;
  int m_valid = 0, m_data = 0, m_index = 0;
  int m_fs = 0, m_fd = 0, m_fe = 0, m_ov = 0;

  // Observations of the DUT, compared only against hand-derived literals.
  int acc_idx[$];
  int acc_data[$];
  int n_start, n_done, n_err, n_ovr;
  int ovr_data, ovr_idx;
  bit chk_rst = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic push(input bit r, input bit s, input bit d, input bit e);
    ent_t x;
    x.rst = r; x.sl = s; x.sd = d; x.eof = e;
    if (hold0 > 0) begin x.rmode = 2'd0; hold0--; end
    else x.rmode = 2'(cur_rmode);
    stream.push_back(x);
  endtask

  // fault: 0 clean, 1 SL glitch at bit 5 of word fw, 2 SL missing at word fw,
  //        3 SL instead of EOF, 4 reset during bit 3 of word fw
  task automatic add_frame(input int fault, input int fw, input bit rnd);
    int d;
    bit s;
    for (int w = 0; w < N; w++) begin
      d = rnd ? int'($urandom_range(0, 4095)) : 32'hA00 + w;
      for (int b = 0; b < W; b++) begin
        if (fault == 4 && w == fw && b == 3) begin
          push(1, 0, 0, 0);
          return;
        end
        s = (b == 0) && !(fault == 2 && w == fw);
        if (fault == 1 && w == fw && b == 5) s = 1;
        push(0, s, d[W-1-b], 0);
      end
    end
    if (fault == 3) begin
      push(0, 1, 0, 0);
      push(0, 0, 0, 0);
      push(0, 0, 0, 0);
    end
    push(0, 0, 0, 1);
    for (int g = 0; g < int'($urandom_range(0, 3)); g++) push(0, 0, 0, 0);
  endtask

  task automatic model_step(input bit r, input bit s, input bit d, input bit e, input bit rdy);
    int done;
    int wv;
    if (r) begin
      m_mode = 0; m_bits = {}; m_idx = 0;
      m_valid = 0; m_data = 0; m_index = 0;
      m_fs = 0; m_fd = 0; m_fe = 0; m_ov = 0;
      return;
    end
    m_fs = 0; m_fd = 0; m_fe = 0; m_ov = 0;
    done = 0; wv = 0;
    case (m_mode)
      0: if (s) begin m_bits = {d}; m_idx = 0; m_fs = 1; m_mode = 1; end
      1: begin
        if (s || e) begin m_fe = 1; m_bits = {}; m_mode = 4; end
        else begin
          m_bits.push_back(d);
          if (m_bits.size() == W) begin
            done = 1;
            foreach (m_bits[i]) wv = (wv << 1) | int'(m_bits[i]);
            m_bits = {};
            m_mode = (m_idx < N - 1) ? 2 : 3;
          end
        end
      end
      2: if (s) begin m_idx++; m_bits = {d}; m_mode = 1; end
         else begin m_fe = 1; m_mode = 4; end
      3: if (e) begin m_fd = 1; m_mode = 0; end
         else begin m_fe = 1; m_mode = 4; end
      default: if (e) m_mode = 0;
    endcase
    if (done != 0) begin
      m_ov = (m_valid != 0 && !rdy) ? 1 : 0;
      m_data = wv; m_index = m_idx; m_valid = 1;
    end else if (m_valid != 0 && rdy) begin
      m_valid = 0;
    end
  endtask

  task automatic clear_obs();
    acc_idx = {}; acc_data = {};
    n_start = 0; n_done = 0; n_err = 0; n_ovr = 0;
    ovr_data = -1; ovr_idx = -1;
  endtask

  task automatic run_stream();
    ent_t x;
    push(0, 0, 0, 0);
    while (stream.size() > 0) begin
      x = stream.pop_front();
      @(negedge clk);
      chk("word_valid", int'(word_valid), m_valid);
      chk("frame_start", int'(frame_start), m_fs);
      chk("frame_done", int'(frame_done), m_fd);
      chk("frame_err", int'(frame_err), m_fe);
      chk("overrun_err", int'(overrun_err), m_ov);
      if (m_valid != 0) begin
        chk("word_data", int'(word_data), m_data);
        chk("word_index", int'(word_index), m_index);
      end
      if (chk_rst) begin
        chk("post_reset_outputs",
            int'({word_valid, frame_start, frame_done, frame_err, overrun_err, word_index, word_data}), 0);
        chk_rst = 0;
      end
      if (frame_start) n_start++;
      if (frame_done) n_done++;
      if (frame_err) n_err++;
      if (overrun_err) begin n_ovr++; ovr_data = int'(word_data); ovr_idx = int'(word_index); end
      reset = x.rst; sl_in = x.sl; sdata_in = x.sd; eof_in = x.eof;
      case (x.rmode)
        2'd0: word_ready = 1'b0;
        2'd1: word_ready = 1'b1;
        default: word_ready = ($urandom_range(0, 3) != 0);
      endcase
      if (x.rst) chk_rst = 1;
      if (word_valid && word_ready) begin
        acc_idx.push_back(int'(word_index));
        acc_data.push_back(int'(word_data));
      end
      model_step(x.rst, x.sl, x.sd, x.eof, word_ready);
    end
  endtask

  initial begin
    reset = 1; sl_in = 0; sdata_in = 0; eof_in = 0; word_ready = 0;
    model_step(1, 0, 0, 0, 0);

    clear_obs();
    push(1, 0, 0, 0); push(1, 0, 0, 0); push(1, 0, 0, 0);
    run_stream();

    // Clean frame, consumer always ready
    clear_obs(); cur_rmode = 1;
    add_frame(0, 0, 0);
    run_stream();
    chk("t1_words", acc_idx.size(), 16);
    for (int k = 0; k < 16 && k < acc_idx.size(); k++) begin
      chk("t1_index", acc_idx[k], k);
      chk("t1_data", acc_data[k], 32'hA00 + k);
    end
    chk("t1_start", n_start, 1);
    chk("t1_done", n_done, 1);
    chk("t1_err", n_err + n_ovr, 0);

    // Consumer stalled across words 0 and 1
    clear_obs(); hold0 = 26;
    add_frame(0, 0, 0);
    run_stream();
    chk("t2_overruns", n_ovr, 1);
    chk("t2_ovr_data", ovr_data, 32'hA01);
    chk("t2_ovr_index", ovr_idx, 1);
    chk("t2_words", acc_idx.size(), 15);
    if (acc_idx.size() > 0) chk("t2_first_data", acc_data[0], 32'hA01);

    // SL glitch inside word 3, then a clean frame
    clear_obs();
    add_frame(1, 3, 0);
    add_frame(0, 0, 0);
    run_stream();
    chk("t3_err", n_err, 1);
    chk("t3_done", n_done, 1);
    chk("t3_start", n_start, 2);
    chk("t3_words", acc_idx.size(), 19);
    if (acc_idx.size() > 3) begin
      chk("t3_resume_index", acc_idx[3], 0);
      chk("t3_resume_data", acc_data[3], 32'hA00);
    end

    // SL missing before word 7
    clear_obs();
    add_frame(2, 7, 0);
    run_stream();
    chk("t4_err", n_err, 1);
    chk("t4_done", n_done, 0);
    chk("t4_words", acc_idx.size(), 7);

    // EOF replaced by SL after word 15
    clear_obs();
    add_frame(3, 0, 0);
    run_stream();
    chk("t5_err", n_err, 1);
    chk("t5_done", n_done, 0);
    chk("t5_words", acc_idx.size(), 16);

    // Reset during word 9, then a clean frame
    clear_obs();
    add_frame(4, 9, 0);
    add_frame(0, 0, 0);
    run_stream();
    chk("t6_words", acc_idx.size(), 25);
    chk("t6_done", n_done, 1);
    if (acc_idx.size() > 24) chk("t6_last_data", acc_data[24], 32'hA0F);

    // Randomised frames, faults and back-pressure
    clear_obs(); cur_rmode = 2;
    for (int f = 0; f < 14; f++) begin
      int fsel;
      fsel = int'($urandom_range(0, 7));
      if (fsel > 4) fsel = 0;
      add_frame(fsel, int'($urandom_range(1, 14)), 1);
      if (fsel == 1 || fsel == 2) push(0, 0, 0, 1);
    end
    cur_rmode = 1;
    for (int g = 0; g < 4; g++) push(0, 0, 0, 0);
    run_stream();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

`default_nettype wire
